// File: rtl/rv32ima_pkg.sv
// Shared RV32IMA core types and sizing constants.
// reg_t/word_t are the default select/data types for a 32 x 32-bit register file.
package rv32ima_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_SEL_W = 5;

    typedef logic [REG_SEL_W-1:0] reg_t;
    typedef logic [XLEN-1:0]      word_t;

    localparam int unsigned REGFILE_NREGS  = 32;
    localparam int unsigned REGFILE_NREAD  = 2;
    localparam int unsigned REGFILE_NWRITE = 1;

    // One-hot decode of a register select; bit 0 is masked because x0 is hardwired.
    function automatic logic [REGFILE_NREGS-1:0] reg_onehot(input reg_t sel);
        logic [REGFILE_NREGS-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        oh[0]   = 1'b0;
        return oh;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of the multi-port register file signals, with design-side and bench-side views.
interface regfile_mp_if
    import rv32ima_pkg::*;
#(
    parameter  int unsigned NREGS  = REGFILE_NREGS,
    parameter  int unsigned DATA_W = XLEN,
    parameter  int unsigned NREAD  = REGFILE_NREAD,
    parameter  int unsigned NWRITE = REGFILE_NWRITE,
    localparam int unsigned SEL_W  = $clog2(NREGS)
) (
    input logic clk,
    input logic nrst
);

    logic [NREAD-1:0][SEL_W-1:0]   rsel;
    logic [NREAD-1:0][DATA_W-1:0]  rdat;
    logic [NREAD-1:0]              rbusy;
    logic [NWRITE-1:0]             wen;
    logic [NWRITE-1:0][SEL_W-1:0]  wsel;
    logic [NWRITE-1:0][DATA_W-1:0] wdat;
    logic [NWRITE-1:0]             wclr;
    logic                          rsv_en;
    logic [SEL_W-1:0]              rsv_sel;
    logic [NREGS-1:0]              busy_vec;

    modport regfile (
        input  clk, nrst, rsel, wen, wsel, wdat, wclr, rsv_en, rsv_sel,
        output rdat, rbusy, busy_vec
    );

    modport tb (
        input  clk, nrst, rdat, rbusy, busy_vec,
        output rsel, wen, wsel, wdat, wclr, rsv_en, rsv_sel
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits tracking in-flight results for RAW hazard detection.
// A reservation in the same cycle as a clearing writeback wins: a new producer was issued.
module regfile_scoreboard
    import rv32ima_pkg::*;
#(
    parameter  int unsigned NREGS  = REGFILE_NREGS,
    parameter  int unsigned NWRITE = REGFILE_NWRITE,
    localparam int unsigned SEL_W  = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [NWRITE-1:0]            wen,
    input  logic [NWRITE-1:0][SEL_W-1:0] wsel,
    input  logic [NWRITE-1:0]            wclr,
    input  logic                         rsv_en,
    input  logic [SEL_W-1:0]             rsv_sel,
    output logic [NREGS-1:0]             busy_vec
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < NWRITE; i++) begin
            if (wen[i] && wclr[i]) begin
                pend_d[wsel[i]] = 1'b0;
            end
        end
        if (rsv_en) begin
            pend_d[rsv_sel] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign busy_vec = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and
// an integrated pending-bit scoreboard. x0 reads as zero and is never busy.
module regfile_mp
    import rv32ima_pkg::*;
#(
    parameter  int unsigned NREGS  = REGFILE_NREGS,
    parameter  int unsigned DATA_W = XLEN,
    parameter  int unsigned NREAD  = REGFILE_NREAD,
    parameter  int unsigned NWRITE = REGFILE_NWRITE,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned SEL_W  = $clog2(NREGS)
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [NREAD-1:0][SEL_W-1:0]   rsel,
    output logic [NREAD-1:0][DATA_W-1:0]  rdat,
    output logic [NREAD-1:0]              rbusy,
    input  logic [NWRITE-1:0]             wen,
    input  logic [NWRITE-1:0][SEL_W-1:0]  wsel,
    input  logic [NWRITE-1:0][DATA_W-1:0] wdat,
    input  logic [NWRITE-1:0]             wclr,
    input  logic                          rsv_en,
    input  logic [SEL_W-1:0]              rsv_sel,
    output logic [NREGS-1:0]              busy_vec
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Later write ports overwrite earlier ones, so the highest index wins on conflicts.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int unsigned i = 0; i < NWRITE; i++) begin
            if (wen[i] && (wsel[i] != '0)) begin
                regs_d[wsel[i]] = wdat[i];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE)
    ) u_scoreboard (
        .clk      (clk),
        .nrst     (nrst),
        .wen      (wen),
        .wsel     (wsel),
        .wclr     (wclr),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .busy_vec (busy_vec)
    );

    // Combinational read; a forwarded clearing write also hides the stale busy bit.
    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int unsigned j = 0; j < NREAD; j++) begin
            rdat[j]  = regs_q[rsel[j]];
            rbusy[j] = busy_vec[rsel[j]];
            if (BYPASS != 0) begin
                for (int unsigned i = 0; i < NWRITE; i++) begin
                    if (wen[i] && (wsel[i] == rsel[j])) begin
                        rdat[j] = wdat[i];
                        if (wclr[i]) begin
                            rbusy[j] = 1'b0;
                        end
                    end
                end
            end
            if (rsel[j] == '0) begin
                rdat[j]  = '0;
                rbusy[j] = 1'b0;
            end
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RV32IMA pipeline.
- Configurable number of combinational read ports and write ports.
- Optional same-cycle write-to-read bypass.
- Integrated scoreboard of per-register pending bits; decode uses it to detect RAW hazards on in-flight results.

Parameters:
NREGS, 32, number of architectural registers (power of two, >= 2)
DATA_W, 32, register width in bits
NREAD, 2, number of read ports
NWRITE, 1, number of write ports
BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads see registered state only
SEL_W, $clog2(NREGS), register select width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
nrst  input  1  asynchronous active-low reset
rsel  input  NREAD x SEL_W  read register selects
rdat  output  NREAD x DATA_W  read data
rbusy  output  NREAD  scoreboard pending bit of each rsel
wen  input  NWRITE  write enables
wsel  input  NWRITE x SEL_W  write register selects
wdat  input  NWRITE x DATA_W  write data
wclr  input  NWRITE  per write port: clear the pending bit of wsel (writeback of a reserved result)
rsv_en  input  1  reserve: mark rsv_sel pending
rsv_sel  input  SEL_W  register to reserve
busy_vec  output  NREGS  full pending-bit vector (debug/hazard unit)

Behaviour:
- Reset (nrst low, async): all registers = 0 and all pending bits = 0.
  - rdat therefore reads 0 on every port and rbusy/busy_vec read 0 while nrst is low.
  - Reset mid-operation discards in-flight writes and reservations.
- Register 0 is hardwired zero.
  - Writes to sel 0 are ignored.
  - rsv_en with rsv_sel = 0 is ignored.
  - rdat for rsel = 0 is always 0; rbusy for rsel = 0 is always 0.
- Write: on the rising edge with wen[i] = 1 and wsel[i] != 0, reg[wsel[i]] <= wdat[i]. Latency is 1 cycle to registered state.
- Write-port conflict: when several ports write the same register in one cycle, the highest port index wins. This applies to both stored data and bypass.
- Read: combinational, zero-cycle latency.
  - BYPASS = 1: if any wen[i] has wsel[i] == rsel[j] != 0, rdat[j] = wdat of the highest such i; otherwise rdat[j] = stored value.
  - BYPASS = 0: rdat[j] = stored value only, so new data appears the cycle after the write.
- Scoreboard (per register, pending bit p[r]):
  - Set: rsv_en & rsv_sel == r -> p[r] <= 1 next edge.
  - Clear: wen[i] & wclr[i] & wsel[i] == r -> p[r] <= 0 next edge.
  - wen without wclr writes data and leaves p unchanged.
  - Set and clear of the same register in the same cycle: set wins (a new producer has been issued).
  - Set of an already-pending register keeps it at 1; clear of a non-pending register keeps it at 0. Neither is an error.
- rbusy[j] = p[rsel[j]], using registered pending state.
  - With BYPASS = 1, rbusy[j] is additionally forced to 0 when a same-cycle clearing write to rsel[j] is present, because the data is forwarded.
  - With BYPASS = 0, no such override applies.
- busy_vec = registered p[], with bit 0 constant 0.
- No X propagation: out-of-range selects cannot occur since NREGS = 2^SEL_W.

Decomposition:
- Shared package rv32ima_pkg:
  - Existing reg_t/word_t remain the defaults for SEL_W=5/DATA_W=32.
  - Add constants REGFILE_NREGS, REGFILE_NREAD, REGFILE_NWRITE.
- Interface: parametrised regfile_mp_if with array signals and regfile/tb modports, mirroring the existing regfile interface.
- Sub-module regfile_scoreboard:
  - Holds the pending bits: set/clear priority logic, async reset, busy_vec output.
  - regfile_mp instantiates it and computes the rbusy bypass override locally.

Test Plan:
- Reset, then assert nrst: read rsel = {5, 0} -> rdat = {0, 0}, rbusy = {0, 0}, busy_vec = 0. Drive nrst low mid-run after writing x5 = 0xDEADBEEF -> rdat[0] = 0 immediately (async).
- BYPASS = 1: wen[0] = 1, wsel = 7, wdat = 0x12345678, rsel[0] = 7 same cycle -> rdat[0] = 0x12345678 that cycle. With BYPASS = 0 -> old value that cycle, 0x12345678 next cycle.
- Write x0 = 0xFFFFFFFF with rsv_en, rsv_sel = 0 -> rdat for rsel 0 stays 0, busy_vec[0] stays 0 in that cycle and after.
- NWRITE = 2: both ports write x3 with 0xAAAA and 0x5555 in the same cycle -> x3 = 0x5555 stored and bypassed.
- Scoreboard sequence:
  - rsv x9 -> next cycle rbusy = 1.
  - Same cycle rsv x9 plus clearing write x9 -> remains 1.
  - Clearing write alone with rsel = 9 -> rbusy = 0 that cycle (BYPASS = 1) and busy_vec[9] = 0 next cycle.
- Random regression: random rsv/write/read traffic on NREAD = 3, NWRITE = 2 against a reference model -> zero mismatches over 10k cycles.
